bitonic_sort_pipe: RTL and testbench

Pipelined, parameterised bitonic sorter. Each transaction carries 2**LP keys, each with a tag, and a per-transaction direction bit. It sorts them through LP*(LP+1)/2 registered compare-exchange layers under a valid/ready handshake. It is the sequential successor to the team's combinational recursive bitonic network, with throughput of one vector per clock. It sits between a producer (e.g. sample buffer) and any consumer needing ordered lanes plus the original lane index/tag.

---
 rtl/bsort_pkg.sv | 58 +++++
 rtl/bsort_cmp_ex.sv | 33 +++
 rtl/bitonic_sort_pipe.sv | 126 ++++++++++++
 tb/tb_bitonic_sort_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsort_pkg.sv
// Shared helpers for the pipelined bitonic sorter.
// The compare-exchange network is described by a flat layer index so the top
// level can build it with plain generate loops instead of recursion.
//   n_layers(lp)             : number of compare-exchange layers for 2**lp lanes
//   layer_blk(layer)         : log2 of the bitonic block size a layer works in
//   layer_dist(layer)        : log2 of the lane distance between partners
//   partner_lane(layer,lane) : the lane that 'lane' is compared against
//   pair_lo_lane(layer,pair) : lower lane of the pair-th compare in a layer
//   lane_desc(lp,layer,lane) : 1 when this lane's block sorts against the
//                              transaction direction
package bsort_pkg;

  // Upper bound on LP, used to keep the elaboration-time search loops finite.
  localparam int MAX_LP = 16;

  function automatic int n_layers(input int lp);
    return (lp * (lp + 1)) / 2;
  endfunction

  // Layers are ordered block size 2,4,8,... and within a block size from the
  // widest distance down to 1, so block size s owns layers s(s-1)/2 .. s(s+1)/2-1.
  function automatic int layer_blk(input int layer);
    int s;
    s = 1;
    while ((s < MAX_LP) && (((s * (s + 1)) / 2) <= layer)) s++;
    return s;
  endfunction

  function automatic int layer_dist(input int layer);
    int s;
    s = layer_blk(layer);
    return s - 1 - (layer - (s * (s - 1)) / 2);
  endfunction

  function automatic int partner_lane(input int layer, input int lane);
    return lane ^ (1 << layer_dist(layer));
  endfunction

  // Insert a zero bit at the partner-distance position of the pair index.
  function automatic int pair_lo_lane(input int layer, input int pair);
    int j;
    j = layer_dist(layer);
    return ((pair >> j) << (j + 1)) | (pair & ((1 << j) - 1));
  endfunction

  // In the recursive network each level sorts its lower half in the parent's
  // direction and its upper half reversed, so a block's direction flips once
  // for every upper-half choice between it and the full vector.
  function automatic logic lane_desc(input int lp, input int layer, input int lane);
    logic flip;
    flip = 1'b0;
    for (int b = layer_blk(layer); b < lp; b++) begin
      flip = flip ^ (((lane >> b) & 1) != 0);
    end
    return flip;
  endfunction

endpackage

// File: rtl/bsort_cmp_ex.sv
// One compare-exchange cell: orders two (key, tag) pairs.
//   keyA_i/tagA_i : pair on the lower lane
//   keyB_i/tagB_i : pair on the upper lane
//   desc_i        : 0 puts the smaller key on the lower lane, 1 the larger
//   keyA_o..tagB_o: ordered pairs; tags always follow their keys
// Equal keys never swap.
module bsort_cmp_ex #(
  parameter int DW = 8,
  parameter int TW = 3
) (
  input  logic [DW-1:0] keyA_i,
  input  logic [TW-1:0] tagA_i,
  input  logic [DW-1:0] keyB_i,
  input  logic [TW-1:0] tagB_i,
  input  logic          desc_i,
  output logic [DW-1:0] keyA_o,
  output logic [TW-1:0] tagA_o,
  output logic [DW-1:0] keyB_o,
  output logic [TW-1:0] tagB_o
);

  logic swap;

  // Strict comparisons keep equal keys in place.
  always_comb begin
    swap   = desc_i ? (keyA_i < keyB_i) : (keyA_i > keyB_i);
    keyA_o = swap ? keyB_i : keyA_i;
    tagA_o = swap ? tagB_i : tagA_i;
    keyB_o = swap ? keyA_i : keyB_i;
    tagB_o = swap ? tagA_i : tagB_i;
  end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorter: one vector of 2**LP (key, tag) lanes per clock.
// Every compare-exchange layer is followed by a register stage; the last
// stage drives the outputs directly.
//   clk, rst             : clock and synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_dir, in_key, in_tag sampled on accept
//   out_valid/out_ready  : output handshake; out_dir, out_key, out_tag held while stalled
//   busy                 : any stage holds a valid vector
module bitonic_sort_pipe #(
  parameter int LP = 3,
  parameter int DW = 8,
  parameter int TW = 3,
  localparam int PN = 1 << LP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_dir,
  input  logic [PN-1:0][DW-1:0]  in_key,
  input  logic [PN-1:0][TW-1:0]  in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_dir,
  output logic [PN-1:0][DW-1:0]  out_key,
  output logic [PN-1:0][TW-1:0]  out_tag,
  output logic                   busy
);

  import bsort_pkg::*;

  localparam int S = n_layers(LP);

  typedef logic [PN-1:0][DW-1:0] keyv_t;
  typedef logic [PN-1:0][TW-1:0] tagv_t;

  logic [S-1:0] validQ, validD, advance;
  logic [S-1:0] dirQ, dirD;
  keyv_t        keyQ [S];
  keyv_t        keyD [S];
  keyv_t        srcKey [S];
  tagv_t        tagQ [S];
  tagv_t        tagD [S];
  tagv_t        srcTag [S];

  // Ready chain: a stage may load when it is empty or its successor loads,
  // evaluated from the output backwards so bubbles collapse in one cycle.
  // Each layer also gets its source vector: the inputs for layer 0, the
  // previous stage's register otherwise.
  always_comb begin
    logic ld;
    ld      = out_ready;
    advance = '0;
    validD  = '0;
    dirD    = '0;
    for (int k = S - 1; k >= 0; k--) begin
      ld         = ~validQ[k] | ld;
      advance[k] = ld;
    end
    validD[0] = in_valid;
    dirD[0]   = in_dir;
    srcKey[0] = in_key;
    srcTag[0] = in_tag;
    for (int k = 1; k < S; k++) begin
      validD[k] = validQ[k-1];
      dirD[k]   = dirQ[k-1];
      srcKey[k] = keyQ[k-1];
      srcTag[k] = tagQ[k-1];
    end
  end

  // One layer of PN/2 compare-exchange cells per stage; the lane pairing and
  // per-block direction come from the package so the schedule is fixed here.
  for (genvar k = 0; k < S; k++) begin : g_layer
    keyv_t dstKey;
    tagv_t dstTag;
    for (genvar p = 0; p < PN / 2; p++) begin : g_pair
      localparam int   LA   = pair_lo_lane(k, p);
      localparam int   LB   = partner_lane(k, LA);
      localparam logic FLIP = lane_desc(LP, k, LA);
      bsort_cmp_ex #(.DW(DW), .TW(TW)) u_cx (
        .keyA_i (srcKey[k][LA]),
        .tagA_i (srcTag[k][LA]),
        .keyB_i (srcKey[k][LB]),
        .tagB_i (srcTag[k][LB]),
        .desc_i (dirD[k] ^ FLIP),
        .keyA_o (dstKey[LA]),
        .tagA_o (dstTag[LA]),
        .keyB_o (dstKey[LB]),
        .tagB_o (dstTag[LB])
      );
    end
    assign keyD[k] = dstKey;
    assign tagD[k] = dstTag;
  end

  // Stage registers. Data only moves when a valid vector arrives, so the
  // output stage keeps its contents across bubbles and stalls. Only the
  // output stage's data is cleared on reset since it is visible at the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      validQ       <= '0;
      dirQ[S-1]    <= 1'b0;
      keyQ[S-1]    <= '0;
      tagQ[S-1]    <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (advance[k]) begin
          validQ[k] <= validD[k];
          if (validD[k]) begin
            dirQ[k] <= dirD[k];
            keyQ[k] <= keyD[k];
            tagQ[k] <= tagD[k];
          end
        end
      end
    end
  end

  assign in_ready  = advance[0] & ~rst;
  assign out_valid = validQ[S-1];
  assign out_dir   = dirQ[S-1];
  assign out_key   = keyQ[S-1];
  assign out_tag   = tagQ[S-1];
  assign busy      = |validQ;

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Self-checking bench for bitonic_sort_pipe at LP=3 (8 lanes, 6 stages).
// A monitor on the falling edge records accepted vectors with their expected
// result and compares every delivered vector in order.
module tb_bitonic_sort_pipe;

  localparam int LP = 3;
  localparam int DW = 8;
  localparam int TW = 3;
  localparam int PN = 8;
  localparam int S  = 6;

  typedef logic [PN-1:0][DW-1:0] keyv_t;
  typedef logic [PN-1:0][TW-1:0] tagv_t;

  typedef struct {
    logic  dir;
    keyv_t key;
    tagv_t tag;
    keyv_t expKey;
    tagv_t expTag;
  } vec_t;

  typedef struct {
    logic  dir;
    keyv_t key;
    tagv_t tag;
    tagv_t inTag;
    bit    permOnly;
    bit    chkLat;
    int    accCyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  in_valid = 1'b0;
  logic  in_dir = 1'b0;
  keyv_t in_key = '0;
  tagv_t in_tag = '0;
  logic  out_ready = 1'b1;
  logic  in_ready, out_valid, out_dir, busy;
  keyv_t out_key;
  tagv_t out_tag;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    outCount = 0;
  exp_t  pending;
  exp_t  expQ [$];
  bit    holding = 1'b0;
  keyv_t heldKey;
  tagv_t heldTag;
  logic  heldDir;
  vec_t  vecs [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitonic_sort_pipe #(.LP(LP), .DW(DW), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dir    (in_dir),
    .in_key    (in_key),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dir   (out_dir),
    .out_key   (out_key),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic keyv_t mkKey(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int    a [PN];
    keyv_t v;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < PN; i++) v[i] = DW'(a[i]);
    return v;
  endfunction

  function automatic tagv_t mkTag(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int    a [PN];
    tagv_t v;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < PN; i++) v[i] = TW'(a[i]);
    return v;
  endfunction

  // Reference ordering: a plain bubble sort carrying tags with their keys.
  function automatic void sortModel(input keyv_t k, input tagv_t t, input logic dir,
                                    output keyv_t ok, output tagv_t ot);
    logic [DW-1:0] tk;
    logic [TW-1:0] tt;
    ok = k;
    ot = t;
    for (int i = 0; i < PN - 1; i++) begin
      for (int j = 0; j < PN - 1 - i; j++) begin
        if (dir ? (ok[j] < ok[j+1]) : (ok[j] > ok[j+1])) begin
          tk = ok[j]; ok[j] = ok[j+1]; ok[j+1] = tk;
          tt = ot[j]; ot[j] = ot[j+1]; ot[j+1] = tt;
        end
      end
    end
  endfunction

  // Distinct random keys so the expected tag order is unambiguous.
  task automatic randVec(output keyv_t k, output tagv_t t);
    bit dup;
    for (int i = 0; i < PN; i++) begin
      do begin
        k[i] = DW'($urandom_range(0, 255));
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (k[j] == k[i]) dup = 1'b1;
      end while (dup);
      t[i] = TW'(i);
    end
  endtask

  // Present one vector and return at the falling edge where it is seen accepted.
  task automatic applyStimulus(input logic dir, input keyv_t k, input tagv_t t,
                               input keyv_t ek, input tagv_t et,
                               input bit permOnly, input bit chkLat);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_dir   = dir;
    in_key   = k;
    in_tag   = t;
    pending.dir      = dir;
    pending.key      = ek;
    pending.tag      = et;
    pending.inTag    = t;
    pending.permOnly = permOnly;
    pending.chkLat   = chkLat;
    pending.accCyc   = 0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("accept", in_ready, 1);
  endtask

  task automatic idleInput();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", expQ.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  // Compare a delivered vector against the oldest outstanding expectation.
  task automatic checkOutput();
    exp_t e;
    int   cnt [1 << TW];
    bit   permOk;
    outCount++;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_out: got key %0h, expected no output (cycle %0d)", out_key, cyc);
      return;
    end
    e = expQ.pop_front();
    check("out_dir", out_dir, e.dir);
    check("out_key", out_key, e.key);
    if (e.permOnly) begin
      foreach (cnt[v]) cnt[v] = 0;
      for (int i = 0; i < PN; i++) begin
        cnt[e.inTag[i]]++;
        cnt[out_tag[i]]--;
      end
      permOk = 1'b1;
      foreach (cnt[v]) if (cnt[v] != 0) permOk = 1'b0;
      check("out_tag_perm", permOk, 1);
    end else begin
      check("out_tag", out_tag, e.tag);
    end
    if (e.chkLat) check("latency", cyc - e.accCyc, S);
  endtask

  // Falling-edge monitor: record accepts, verify stalled outputs hold, and
  // compare every transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_t e;
        e = pending;
        e.accCyc = cyc;
        expQ.push_back(e);
      end
      if (holding) begin
        check("hold_valid", out_valid, 1);
        check("hold_key", out_key, heldKey);
        check("hold_tag", out_tag, heldTag);
        check("hold_dir", out_dir, heldDir);
      end
      if (out_valid && out_ready) checkOutput();
    end
    holding = (out_valid === 1'b1) && (out_ready === 1'b0) && !rst;
    heldKey = out_key;
    heldTag = out_tag;
    heldDir = out_dir;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    keyv_t k, ek;
    tagv_t t, et;
    keyv_t bpKey [7];
    tagv_t bpTag [7];
    keyv_t bpExpKey [7];
    tagv_t bpExpTag [7];
    int    acc, base;

    vecs[0] = '{dir: 1'b0, key: mkKey(7,3,5,1,8,2,6,4), tag: mkTag(0,1,2,3,4,5,6,7),
                expKey: mkKey(1,2,3,4,5,6,7,8), expTag: mkTag(3,5,1,7,2,6,0,4)};
    vecs[1] = '{dir: 1'b1, key: mkKey(7,3,5,1,8,2,6,4), tag: mkTag(0,1,2,3,4,5,6,7),
                expKey: mkKey(8,7,6,5,4,3,2,1), expTag: mkTag(4,0,6,2,7,1,5,3)};
    vecs[2] = '{dir: 1'b0, key: mkKey(0,255,128,1,254,2,127,129), tag: mkTag(0,1,2,3,4,5,6,7),
                expKey: mkKey(0,1,2,127,128,129,254,255), expTag: mkTag(0,3,5,6,2,7,4,1)};
    vecs[3] = '{dir: 1'b1, key: mkKey(0,255,128,1,254,2,127,129), tag: mkTag(0,1,2,3,4,5,6,7),
                expKey: mkKey(255,254,129,128,127,2,1,0), expTag: mkTag(1,4,7,2,6,5,3,0)};
    vecs[4] = '{dir: 1'b0, key: mkKey(10,20,30,40,50,60,70,80), tag: mkTag(0,1,2,3,4,5,6,7),
                expKey: mkKey(10,20,30,40,50,60,70,80), expTag: mkTag(0,1,2,3,4,5,6,7)};

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_key", out_key, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_dir", out_dir, 0);
    check("ready_after_rst", in_ready, 1);

    // Directed single vectors
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].dir, vecs[i].key, vecs[i].tag, vecs[i].expKey, vecs[i].expTag, 1'b0, 1'b1);
      idleInput();
      waitDrain();
    end

    // Ten back-to-back vectors, alternating direction
    for (int i = 0; i < 10; i++) begin
      randVec(k, t);
      sortModel(k, t, (i % 2) == 1, ek, et);
      applyStimulus((i % 2) == 1, k, t, ek, et, 1'b0, 1'b1);
    end
    idleInput();
    waitDrain();

    // Backpressure: fill all stages, then release
    for (int i = 0; i < 7; i++) begin
      randVec(bpKey[i], bpTag[i]);
      sortModel(bpKey[i], bpTag[i], (i % 2) == 0, bpExpKey[i], bpExpTag[i]);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_dir   = (acc % 2) == 0;
      in_key   = bpKey[acc];
      in_tag   = bpTag[acc];
      pending.dir      = (acc % 2) == 0;
      pending.key      = bpExpKey[acc];
      pending.tag      = bpExpTag[acc];
      pending.inTag    = bpTag[acc];
      pending.permOnly = 1'b0;
      pending.chkLat   = 1'b0;
      @(negedge clk);
      if (in_ready && acc < 6) acc++;
      else if (in_ready) acc = 99;
    end
    check("bp_accepted", acc, 6);
    check("bp_in_ready", in_ready, 0);
    check("bp_busy", busy, 1);
    base = outCount;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_return", in_ready, 1);
    waitDrain();
    check("bp_out_count", outCount - base, 6);

    // All keys equal: keys unchanged, tags a permutation
    applyStimulus(1'b0, mkKey(5,5,5,5,5,5,5,5), mkTag(0,1,2,3,4,5,6,7),
                  mkKey(5,5,5,5,5,5,5,5), mkTag(0,1,2,3,4,5,6,7), 1'b1, 1'b1);
    idleInput();
    waitDrain();

    // Reset with four vectors in flight
    for (int i = 0; i < 4; i++) begin
      randVec(k, t);
      sortModel(k, t, 1'b0, ek, et);
      applyStimulus(1'b0, k, t, ek, et, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    base = outCount;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    repeat (12) @(negedge clk);
    check("mid_rst_no_output", outCount - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
